// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: encodes symbolic RV32I requests into 32-bit instruction
// words and streams them into instruction memory, optionally terminating the
// program with an EBREAK word that the core treats as its halt.
module inst_encoder_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              finish,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);

    localparam logic [31:0]   EBREAK_WORD = 32'h0010_0073;
    localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    // Instruction formats; SH is the shift-immediate flavour of the I format.
    typedef enum logic [2:0] {F_R, F_I, F_SH, F_U, F_B, F_J, F_S, F_E} fmt_t;

    typedef enum logic [1:0] {S_LOAD, S_TERM, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     wptr_q, wptr_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [31:0]         im_wdata_q, im_wdata_d;
    logic                err_q, err_d;

    fmt_t                fmt;
    logic [6:0]          opc;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic                op_ok;
    logic                imm_ok;
    logic signed [31:0]  imm_s;
    logic [31:0]         enc;
    logic                fire;

    assign full      = (state_q == S_LOAD) && (wptr_q == LAST_SLOT);
    assign req_ready = (state_q == S_LOAD) && !full;
    assign fire      = req_valid && req_ready;
    assign done      = (state_q == S_DONE);
    assign count     = wptr_q;
    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign err       = err_q;
    assign imm_s     = req_imm;

    // Decode the symbolic op into format, opcode and function fields.
    always_comb begin
        fmt   = F_R;
        opc   = 7'b0110011;
        f3    = 3'b000;
        f7    = 7'b0000000;
        op_ok = 1'b1;
        case (req_op)
            5'd0:  f3 = 3'b000;
            5'd1:  begin f3 = 3'b000; f7 = 7'b0100000; end
            5'd2:  f3 = 3'b111;
            5'd3:  f3 = 3'b110;
            5'd4:  f3 = 3'b001;
            5'd5:  f3 = 3'b101;
            5'd6:  begin f3 = 3'b101; f7 = 7'b0100000; end
            5'd7:  begin fmt = F_I;  opc = 7'b0010011; f3 = 3'b000; end
            5'd8:  begin fmt = F_SH; opc = 7'b0010011; f3 = 3'b001; end
            5'd9:  begin fmt = F_SH; opc = 7'b0010011; f3 = 3'b101; end
            5'd10: begin fmt = F_SH; opc = 7'b0010011; f3 = 3'b101; f7 = 7'b0100000; end
            5'd11: begin fmt = F_U;  opc = 7'b0110111; end
            5'd12: begin fmt = F_U;  opc = 7'b0010111; end
            5'd13: begin fmt = F_B;  opc = 7'b1100011; f3 = 3'b000; end
            5'd14: begin fmt = F_B;  opc = 7'b1100011; f3 = 3'b001; end
            5'd15: begin fmt = F_B;  opc = 7'b1100011; f3 = 3'b100; end
            5'd16: begin fmt = F_B;  opc = 7'b1100011; f3 = 3'b101; end
            5'd17: begin fmt = F_B;  opc = 7'b1100011; f3 = 3'b110; end
            5'd18: begin fmt = F_B;  opc = 7'b1100011; f3 = 3'b111; end
            5'd19: begin fmt = F_J;  opc = 7'b1101111; end
            5'd20: begin fmt = F_I;  opc = 7'b1100111; f3 = 3'b000; end
            5'd21: begin fmt = F_I;  opc = 7'b0000011; f3 = 3'b010; end
            5'd22: begin fmt = F_S;  opc = 7'b0100011; f3 = 3'b010; end
            5'd23: fmt = F_E;
            default: op_ok = 1'b0;
        endcase
    end

    // Assemble the instruction word and check the immediate fits its format.
    always_comb begin
        enc    = 32'h0;
        imm_ok = 1'b1;
        case (fmt)
            F_R: enc = {f7, req_rs2, req_rs1, f3, req_rd, opc};
            F_I: begin
                enc    = {req_imm[11:0], req_rs1, f3, req_rd, opc};
                imm_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            F_SH: begin
                enc    = {f7, req_imm[4:0], req_rs1, f3, req_rd, opc};
                imm_ok = (req_imm[31:5] == 27'd0);
            end
            F_U: begin
                enc    = {req_imm[31:12], req_rd, opc};
                imm_ok = (req_imm[11:0] == 12'd0);
            end
            F_B: begin
                enc    = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, f3,
                          req_imm[4:1], req_imm[11], opc};
                imm_ok = !req_imm[0] && (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094);
            end
            F_J: begin
                enc    = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                          req_rd, opc};
                imm_ok = !req_imm[0] && (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);
            end
            F_S: begin
                enc    = {req_imm[11:5], req_rs2, req_rs1, f3, req_imm[4:0], opc};
                imm_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            F_E: enc = EBREAK_WORD;
            default: enc = 32'h0;
        endcase
    end

    // Loader FSM: accept and write requests, then append the terminator.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        err_d      = err_q;
        if (clear) begin
            // clear wins over any fire/finish in the same cycle
            state_d = S_LOAD;
            wptr_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (fire) begin
                        if (op_ok && imm_ok) begin
                            im_we_d    = 1'b1;
                            im_addr_d  = wptr_q[ADDR_W-1:0];
                            im_wdata_d = enc;
                            wptr_d     = wptr_q + PTR_ONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (finish) begin
                        state_d = S_TERM;
                    end
                end
                S_TERM: begin
                    // wptr is at most the reserved last slot here, so the slice is exact
                    im_we_d    = 1'b1;
                    im_addr_d  = wptr_q[ADDR_W-1:0];
                    im_wdata_d = EBREAK_WORD;
                    wptr_d     = wptr_q + PTR_ONE;
                    state_d    = S_DONE;
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_LOAD;
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD;
            wptr_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench for inst_encoder_loader with a field-level RV32I model.
module tb_inst_encoder_loader;

    localparam int AW   = 4;
    localparam int LAST = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_op;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [31:0]   req_imm;
    logic          finish;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic [AW:0]   count;
    logic          full;
    logic          done;
    logic          err;

    inst_encoder_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .finish(finish), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .count(count), .full(full), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [AW+31:0] exp_q[$];

    // model state: 0 loading, 1 terminator pending, 2 finished
    int mstate = 0;
    int mwptr  = 0;
    int merr   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: table of opcode/funct fields, then per-format packing.
    function automatic logic [31:0] model_enc(int op, int rd, int rs1, int rs2, logic [31:0] imm);
        int fmt, opc, f3, f7;
        logic [31:0] r, rr, ra, rb, rf;
        int bf3[6];
        bf3 = '{0, 1, 4, 5, 6, 7};
        f7 = 0; f3 = 0; opc = 'h33; fmt = 0;
        if (op <= 6) begin
            int rf3[7];
            rf3 = '{0, 0, 7, 6, 1, 5, 5};
            f3 = rf3[op];
            if (op == 1 || op == 6) f7 = 32;
        end else if (op == 7)  begin fmt = 1; opc = 'h13; end
        else if (op <= 10)     begin fmt = 2; opc = 'h13; f3 = (op == 8) ? 1 : 5; f7 = (op == 10) ? 32 : 0; end
        else if (op <= 12)     begin fmt = 3; opc = (op == 11) ? 'h37 : 'h17; end
        else if (op <= 18)     begin fmt = 4; opc = 'h63; f3 = bf3[op-13]; end
        else if (op == 19)     begin fmt = 5; opc = 'h6F; end
        else if (op == 20)     begin fmt = 1; opc = 'h67; end
        else if (op == 21)     begin fmt = 1; opc = 'h03; f3 = 2; end
        else if (op == 22)     begin fmt = 6; opc = 'h23; f3 = 2; end
        else                   fmt = 7;
        ra = 32'(opc) + (32'(f3) << 12) + (32'(rs1) << 15);
        rr = 32'(rd) << 7;
        rb = 32'(rs2) << 20;
        rf = 32'(f7) << 25;
        case (fmt)
            0: r = ra + rr + rb + rf;
            1: r = ra + rr + ((imm & 32'hFFF) << 20);
            2: r = ra + rr + rf + ((imm & 32'h1F) << 20);
            3: r = 32'(opc) + rr + (imm & 32'hFFFF_F000);
            4: r = ra + rb + (32'(imm[12]) << 31) + (32'(imm[10:5]) << 25)
                   + (32'(imm[4:1]) << 8) + (32'(imm[11]) << 7);
            5: r = 32'(opc) + rr + (32'(imm[20]) << 31) + (32'(imm[10:1]) << 21)
                   + (32'(imm[11]) << 20) + (32'(imm[19:12]) << 12);
            6: r = ra + rb + ((imm >> 5) << 25) + ((imm & 32'h1F) << 7);
            default: r = 32'h0010_0073;
        endcase
        return r;
    endfunction

    function automatic bit model_ok(int op, logic [31:0] imm);
        longint v;
        v = longint'($signed(imm));
        if (op >= 24) return 0;
        if (op == 7 || op == 20 || op == 21 || op == 22) return v >= -2048 && v <= 2047;
        if (op >= 8 && op <= 10)  return v >= 0 && v <= 31;
        if (op == 11 || op == 12) return (imm & 32'hFFF) == 0;
        if (op >= 13 && op <= 18) return (v % 2 == 0) && v >= -4096 && v <= 4094;
        if (op == 19)             return (v % 2 == 0) && v >= -1048576 && v <= 1048574;
        return 1;
    endfunction

    // Produce an op/imm pair; force_ok keeps it legal.
    task automatic gen(input bit force_ok, output int op, output logic [31:0] imm);
        bit wild;
        wild = !force_ok && ($urandom_range(0, 4) == 0);
        op = (!force_ok && $urandom_range(0, 15) == 0) ? int'($urandom_range(24, 31))
                                                       : int'($urandom_range(0, 23));
        if (wild)                         imm = $urandom;
        else if (op >= 8 && op <= 10)     imm = $urandom_range(0, 31);
        else if (op == 11 || op == 12)    imm = $urandom & 32'hFFFF_F000;
        else if (op >= 13 && op <= 18)    imm = 32'(2 * (int'($urandom_range(0, 4095)) - 2048));
        else if (op == 19)                imm = 32'(2 * (int'($urandom_range(0, 1048575)) - 524288));
        else                              imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        if (force_ok && !model_ok(op, imm)) begin
            op = 0;
        end
    endtask

    // One clock of stimulus plus model update and post-edge status checks.
    task automatic step(input int v, input int op, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input int fin, input int clr,
                        input int use_lit, input logic [31:0] lit);
        logic [31:0] w;
        req_valid = v[0]; req_op = op[4:0]; req_rd = rd[4:0]; req_rs1 = rs1[4:0];
        req_rs2 = rs2[4:0]; req_imm = imm; finish = fin[0]; clear = clr[0];
        #1;
        chk("req_ready", req_ready, (mstate == 0 && mwptr != LAST));
        chk("full", full, (mstate == 0 && mwptr == LAST));
        @(posedge clk);
        if (clr != 0) begin
            mstate = 0; mwptr = 0; merr = 0;
        end else if (mstate == 1) begin
            exp_q.push_back({4'(mwptr), 32'h0010_0073});
            mwptr++; mstate = 2;
        end else if (mstate == 0) begin
            if (v != 0 && mwptr != LAST) begin
                if (model_ok(op, imm)) begin
                    w = use_lit != 0 ? lit : model_enc(op, rd, rs1, rs2, imm);
                    exp_q.push_back({4'(mwptr), w});
                    mwptr++;
                end else begin
                    merr = 1;
                end
            end
            if (fin != 0) mstate = 1;
        end
        #1;
        req_valid = 1'b0; finish = 1'b0; clear = 1'b0;
        chk("count", count, mwptr);
        chk("err", err, merr);
        chk("done", done, mstate == 2);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            logic [AW+31:0] e;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {im_addr, im_wdata}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", im_addr, e[AW+31:32]);
                chk("wr_data", im_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        logic [31:0] imm;
        rst = 1'b1; clear = 1'b0; req_valid = 1'b0; req_op = '0; req_rd = '0;
        req_rs1 = '0; req_rs2 = '0; req_imm = '0; finish = 1'b0;
        #8;
        chk("rst_we", im_we, 0);
        chk("rst_addr", im_addr, 0);
        chk("rst_wdata", im_wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", req_ready, 1);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        // ADDI x1, x0, 5
        step(1, 7, 1, 0, 0, 32'd5, 0, 0, 1, 32'h0050_0093);
        // ADD then SUB back to back
        step(1, 0, 3, 1, 2, 32'h0, 0, 0, 1, 32'h0020_81B3);
        step(1, 1, 3, 1, 2, 32'h0, 0, 0, 1, 32'h4020_81B3);
        chk("b2b_we", im_we, 1);
        // branch/jump encodings and a misaligned branch
        step(1, 13, 0, 1, 2, -32'sd8, 0, 0, 1, 32'hFE20_8CE3);
        step(1, 19, 1, 0, 0, 32'd16, 0, 0, 1, 32'h0100_00EF);
        step(1, 13, 0, 1, 2, 32'd3, 0, 0, 0, 32'h0);
        chk("beq_odd_err", err, 1);
        // fire together with finish, then terminator
        step(1, 22, 0, 5, 6, -32'sd4, 1, 0, 0, 32'h0);
        step(1, 7, 1, 0, 0, 32'd1, 0, 0, 0, 32'h0);
        chk("term_we", im_we, 1);
        chk("term_word", im_wdata, 32'h0010_0073);
        step(1, 7, 1, 0, 0, 32'd1, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        // terminator only, empty program
        step(0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0);
        idle(); idle();
        step(0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        // fill every slot but the last, then terminate
        for (int i = 0; i < LAST; i++) begin
            gen(1, op, imm);
            step(1, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 imm, 0, 0, 0, 32'h0);
        end
        chk("fill_full", full, 1);
        step(1, 0, 1, 1, 1, 32'h0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 32'h0);
        idle();
        chk("fill_count", count, LAST + 1);
        // asynchronous reset while the terminator is pending
        step(0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        step(1, 2, 4, 5, 6, 32'h0, 0, 0, 0, 32'h0);
        step(1, 3, 4, 5, 6, 32'h0, 1, 0, 0, 32'h0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_we", im_we, 0);
        chk("arst_count", count, 0);
        chk("arst_done", done, 0);
        mstate = 0; mwptr = 0; merr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        // illegal op
        step(1, 25, 1, 1, 1, 32'h0, 0, 0, 0, 32'h0);
        chk("op25_err", err, 1);
        step(0, 0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0);

        // randomized traffic
        for (int i = 0; i < 700; i++) begin
            int v, fin, clr;
            gen(0, op, imm);
            v   = ($urandom_range(0, 4) != 0) ? 1 : 0;
            fin = ($urandom_range(0, 13) == 0) ? 1 : 0;
            clr = ($urandom_range(0, 7) == 0 && mstate == 2) || ($urandom_range(0, 60) == 0) ? 1 : 0;
            step(v, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 imm, fin, clr, 0, 32'h0);
        end
        idle(); idle();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
